time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter BLINK_PER, default 8, clk_i cycles per blink_o half-period in set states.
REQ-002 Parameter RPT_DLY, default 16, clk_i cycles inc_btn_i must be held before auto-repeat starts.
REQ-003 Parameter RPT_PER, default 4, clk_i cycles between auto-repeat increments.
REQ-004 The block SHALL have a single clock, clk_i (input, 1), rising-edge active.
REQ-005 rst_ni (input, 1) SHALL be an asynchronous, active-low reset.
REQ-006 mode_btn_i (input, 1): synchronized, debounced mode button level.
REQ-007 inc_btn_i (input, 1): synchronized, debounced increment button level.
REQ-008 cur_hour_i (input, 5): current hour from the 0-23 counter.
REQ-009 cur_min_i (input, 6): current minute from the 0-59 counter.
REQ-010 hour_ival_o (output, 5): edited hour, drives the hour counter initial value.
REQ-011 min_ival_o (output, 6): edited minute, drives the minute counter initial value.
REQ-012 load_o (output, 1): one-cycle active-high pulse, drives counter reset/load.
REQ-013 edit_o (output, 2): 00 run, 01 editing hour, 10 editing minute.
REQ-014 blink_o (output, 1): blink enable for the display field being edited.

Function
REQ-015 FSM states: RUN, SET_HOUR, SET_MIN, LOAD.
REQ-016 Rising edges of each button are detected by a registered edge detector; the action occurs on the clk_i edge after the input first samples 1.
REQ-017 RUN + mode edge -> SET_HOUR; on the same edge, cur_hour_i/cur_min_i are captured into hour_ival_o/min_ival_o.
REQ-018 SET_HOUR + mode edge -> SET_MIN; SET_MIN + mode edge -> LOAD; LOAD -> RUN unconditionally after 1 cycle.
REQ-019 load_o = 1 exactly in the LOAD state (one cycle), otherwise 0; hour_ival_o/min_ival_o are stable during LOAD.
REQ-020 SET_HOUR + inc event: hour_ival_o increments, 23 -> 0 wrap; SET_MIN + inc event: min_ival_o increments, 59 -> 0 wrap.
REQ-021 Captured values >23 (hour) or >59 (min) are clamped to 0 at capture.
REQ-022 Inc events in RUN or LOAD are ignored.
REQ-023 Mode and inc events in the same cycle: mode wins, inc is discarded.
REQ-024 blink_o = 0 in RUN/LOAD; in set states it toggles every BLINK_PER cycles, starting at 1 on state entry (counter restarts on each state change).
REQ-025 edit_o is decoded directly from state; LOAD reports 00.

Reset
REQ-026 rst_ni low SHALL asynchronously force: state RUN, hour_ival_o 0, min_ival_o 0, load_o 0, edit_o 00, blink_o 0, edge-detect and repeat counters 0.
REQ-027 Reset mid-edit discards edits with no load_o pulse; a button held through reset deassertion generates no event.

Configuration
REQ-028 With macro TIME_SET_AUTO_REPEAT_EN defined, holding inc_btn_i in a set state generates one event on the press edge, the next after RPT_DLY cycles held, then one every RPT_PER cycles until release.
REQ-029 Without TIME_SET_AUTO_REPEAT_EN, only the press edge generates an event; RPT_DLY/RPT_PER are unused.

Structure
REQ-030 Shared package watch_pkg holds the FSM state typedef, HOUR_MAX=23, MIN_MAX=59 and the edit_o codes.
REQ-031 One sub-module, btn_evt, contains the edge detect and auto-repeat logic and is instantiated once per button (repeat disabled for mode).

Verification
REQ-032 Reset release, no buttons -> all outputs 0, state RUN for 100 cycles.
REQ-033 cur_hour_i=22, cur_min_i=58; mode, inc x3, mode, inc x2, mode -> hour_ival_o=1, min_ival_o=0, a single load_o pulse, edit_o back to 00.
REQ-034 Mode and inc rising in the same cycle from SET_HOUR -> state SET_MIN, hour_ival_o unchanged.
REQ-035 With AUTO_REPEAT_EN, inc held 16+4*3 cycles in SET_MIN from min 10 -> min_ival_o=14; without the macro -> 11.
REQ-036 rst_ni asserted low in SET_MIN mid-cycle -> outputs 0 immediately (async), load_o never pulses.
REQ-037 In SET_HOUR, blink_o = 1 for 8 cycles, then 0 for 8 cycles; on transition to RUN, blink_o = 0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting logic: FSM states,
// field limits and edit_o codes.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_LOAD     = 2'd3
  } state_t;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  localparam logic [1:0] EDIT_RUN  = 2'b00;
  localparam logic [1:0] EDIT_HOUR = 2'b01;
  localparam logic [1:0] EDIT_MIN  = 2'b10;

  function automatic logic [1:0] edit_code(input state_t s);
    case (s)
      ST_SET_HOUR: edit_code = EDIT_HOUR;
      ST_SET_MIN:  edit_code = EDIT_MIN;
      default:     edit_code = EDIT_RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_evt.sv
// Button event generator: registered rising-edge detect plus optional
// auto-repeat (first repeat after RPT_DLY held cycles, then every RPT_PER).
module btn_evt
  import watch_pkg::*;
#(
  parameter bit REPEAT_EN = 1'b0,
  parameter int RPT_DLY   = 16,
  parameter int RPT_PER   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic evt_o
);

  localparam int CNT_W = $clog2(RPT_DLY + 1);

  logic             r_btn;
  logic             r_btn_d;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             w_press;
  logic             w_held;
  logic             w_rpt;

  assign w_press = r_btn & ~r_btn_d;
  assign w_held  = r_btn & r_btn_d;
  assign w_rpt   = REPEAT_EN & w_held & (r_cnt == CNT_W'(RPT_DLY));
  assign evt_o   = w_press | w_rpt;

  // r_armed seeds the delayed copy from the live input on the first cycle out
  // of reset, so a button held through reset release is not seen as a press.
  // r_cnt only runs after a genuine press, for the same reason.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_btn   <= 1'b0;
      r_btn_d <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_btn   <= btn_i;
      r_btn_d <= r_armed ? r_btn : btn_i;
      r_armed <= 1'b1;
      if (w_press)
        r_cnt <= CNT_W'(1);
      else if (!w_held)
        r_cnt <= '0;
      else if (w_rpt)
        r_cnt <= CNT_W'(RPT_DLY - RPT_PER + 1);
      else if (r_cnt != '0 && r_cnt != CNT_W'(RPT_DLY))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Watch time-setting controller: mode button cycles RUN/SET_HOUR/SET_MIN/LOAD,
// inc button edits the field. Macro TIME_SET_AUTO_REPEAT_EN enables inc auto-repeat.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int BLINK_PER = 8,
  parameter int RPT_DLY   = 16,
  parameter int RPT_PER   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  output logic [4:0] hour_ival_o,
  output logic [5:0] min_ival_o,
  output logic       load_o,
  output logic [1:0] edit_o,
  output logic       blink_o
);

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam bit INC_RPT_EN = 1'b1;
`else
  localparam bit INC_RPT_EN = 1'b0;
`endif

  localparam int BL_W = $clog2(BLINK_PER + 1);

  state_t          r_state;
  logic [4:0]      r_hour;
  logic [5:0]      r_min;
  logic            r_load;
  logic [1:0]      r_edit;
  logic            r_blink;
  logic [BL_W-1:0] r_bcnt;
  logic            w_mode_evt;
  logic            w_inc_evt;
  logic            w_bl_wrap;

  btn_evt #(
    .REPEAT_EN (1'b0),
    .RPT_DLY   (RPT_DLY),
    .RPT_PER   (RPT_PER)
  ) u_mode_evt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (mode_btn_i),
    .evt_o  (w_mode_evt)
  );

  btn_evt #(
    .REPEAT_EN (INC_RPT_EN),
    .RPT_DLY   (RPT_DLY),
    .RPT_PER   (RPT_PER)
  ) u_inc_evt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (inc_btn_i),
    .evt_o  (w_inc_evt)
  );

  function automatic logic [4:0] clamp_hour(input logic [4:0] v);
    clamp_hour = (v > HOUR_MAX) ? 5'd0 : v;
  endfunction

  function automatic logic [5:0] clamp_min(input logic [5:0] v);
    clamp_min = (v > MIN_MAX) ? 6'd0 : v;
  endfunction

  function automatic logic [4:0] next_hour(input logic [4:0] v);
    next_hour = (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] next_min(input logic [5:0] v);
    next_min = (v >= MIN_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  assign w_bl_wrap = (r_bcnt == BL_W'(BLINK_PER - 1));

  // Every state change reloads the blink phase (on, count 0); mode always
  // takes priority over a coincident inc event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
      r_hour  <= 5'd0;
      r_min   <= 6'd0;
      r_load  <= 1'b0;
      r_edit  <= EDIT_RUN;
      r_blink <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_blink <= 1'b0;
          r_bcnt  <= '0;
          if (w_mode_evt) begin
            r_state <= ST_SET_HOUR;
            r_edit  <= edit_code(ST_SET_HOUR);
            r_hour  <= clamp_hour(cur_hour_i);
            r_min   <= clamp_min(cur_min_i);
            r_blink <= 1'b1;
          end
        end
        ST_SET_HOUR: begin
          if (w_mode_evt) begin
            r_state <= ST_SET_MIN;
            r_edit  <= edit_code(ST_SET_MIN);
            r_blink <= 1'b1;
            r_bcnt  <= '0;
          end else begin
            if (w_inc_evt)
              r_hour <= next_hour(r_hour);
            r_bcnt <= w_bl_wrap ? '0 : r_bcnt + 1'b1;
            if (w_bl_wrap)
              r_blink <= ~r_blink;
          end
        end
        ST_SET_MIN: begin
          if (w_mode_evt) begin
            r_state <= ST_LOAD;
            r_edit  <= edit_code(ST_LOAD);
            r_load  <= 1'b1;
            r_blink <= 1'b0;
            r_bcnt  <= '0;
          end else begin
            if (w_inc_evt)
              r_min <= next_min(r_min);
            r_bcnt <= w_bl_wrap ? '0 : r_bcnt + 1'b1;
            if (w_bl_wrap)
              r_blink <= ~r_blink;
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
          r_edit  <= edit_code(ST_RUN);
          r_blink <= 1'b0;
          r_bcnt  <= '0;
        end
        default: begin
          r_state <= ST_RUN;
          r_edit  <= EDIT_RUN;
          r_blink <= 1'b0;
          r_bcnt  <= '0;
        end
      endcase
    end
  end

  assign hour_ival_o = r_hour;
  assign min_ival_o  = r_min;
  assign load_o      = r_load;
  assign edit_o      = r_edit;
  assign blink_o     = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected output words are queued when
// stimulus is driven and popped/compared when the DUT output settles.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [4:0] hour_ival;
  logic [5:0] min_ival;
  logic       load;
  logic [1:0] edit;
  logic       blink;

  time_set_ctrl #(.BLINK_PER(8), .RPT_DLY(16), .RPT_PER(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mode_btn_i  (mode_btn),
    .inc_btn_i   (inc_btn),
    .cur_hour_i  (cur_hour),
    .cur_min_i   (cur_min),
    .hour_ival_o (hour_ival),
    .min_ival_o  (min_ival),
    .load_o      (load),
    .edit_o      (edit),
    .blink_o     (blink)
  );

  always #5 clk = ~clk;

  // Output word layout: {edit[14:13], load[12], blink[11], hour[10:6], min[5:0]}
  typedef struct {
    string       name;
    logic [14:0] val;
    logic [14:0] mask;
  } exp_t;

  localparam logic [14:0] M_ALL   = 15'h7fff;
  localparam logic [14:0] M_NOBL  = 15'h77ff;
  localparam logic [14:0] M_BLINK = 15'h6800;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_load = 0;
  logic [14:0] obs;

  assign obs = {edit, load, blink, hour_ival, min_ival};

  always @(posedge clk) if (load === 1'b1) n_load <= n_load + 1;

  function automatic logic [14:0] pk(input logic [1:0] ed, input logic ld, input logic bl,
                                     input logic [4:0] h, input logic [5:0] m);
    pk = {ed, ld, bl, h, m};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    exp_q.push_back('{"reset_async", pk(2'b00, 0, 0, 5'd0, 6'd0), M_ALL});
    #2;
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back('{"idle_after_reset", pk(2'b00, 0, 0, 5'd0, 6'd0), M_ALL});
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, i, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_set_sequence;
    logic       is_inc[8]  = '{0, 1, 1, 1, 0, 1, 1, 0};
    logic [4:0] eh[8]      = '{22, 23, 0, 1, 1, 1, 1, 1};
    logic [5:0] em[8]      = '{58, 58, 58, 58, 58, 59, 0, 0};
    logic [1:0] ee[8]      = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    int         load_start;
    load_start = n_load;
    cur_hour = 5'd22; cur_min = 6'd58;
    for (int s = 0; s < 8; s++) begin
      if (is_inc[s]) inc_btn = 1'b1; else mode_btn = 1'b1;
      exp_q.push_back('{"set_seq_step", pk(ee[s], (s == 7), 0, eh[s], em[s]), M_NOBL});
      tick(2);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++; $display("FAIL %s %0d: got %h expected %h", e.name, s, obs & e.mask, e.val & e.mask);
      end
      inc_btn = 1'b0; mode_btn = 1'b0;
      tick(2);
    end
    exp_q.push_back('{"set_seq_end_run", pk(2'b00, 0, 0, 5'd1, 6'd0), M_ALL});
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    n_cmp++;
    if ((n_load - load_start) !== 1) begin
      n_fail++; $display("FAIL set_seq_load_pulses: got %0d expected 1", n_load - load_start);
    end
  endtask

  task automatic test_mode_inc_same;
    cur_hour = 5'd22; cur_min = 6'd58;
    mode_btn = 1'b1;
    exp_q.push_back('{"same_enter_hour", pk(2'b01, 0, 0, 5'd22, 6'd58), M_NOBL});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b0;
    tick(2);
    mode_btn = 1'b1; inc_btn = 1'b1;
    exp_q.push_back('{"same_mode_wins", pk(2'b10, 0, 0, 5'd22, 6'd58), M_NOBL});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b0; inc_btn = 1'b0;
    tick(2);
    mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(2);
  endtask

  task automatic test_clamp;
    cur_hour = 5'd30; cur_min = 6'd63;
    mode_btn = 1'b1;
    exp_q.push_back('{"clamp_capture", pk(2'b01, 0, 0, 5'd0, 6'd0), M_NOBL});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b0; tick(2);
    inc_btn = 1'b1;
    exp_q.push_back('{"clamp_then_inc", pk(2'b01, 0, 0, 5'd1, 6'd0), M_NOBL});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    inc_btn = 1'b0; tick(2);
    for (int k = 0; k < 2; k++) begin
      mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(2);
    end
    exp_q.push_back('{"clamp_back_run", pk(2'b00, 0, 0, 5'd1, 6'd0), M_ALL});
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
  endtask

  task automatic test_auto_repeat;
    logic [5:0] final_min;
`ifdef TIME_SET_AUTO_REPEAT_EN
    final_min = 6'd14;
`else
    final_min = 6'd11;
`endif
    cur_hour = 5'd5; cur_min = 6'd10;
    for (int k = 0; k < 2; k++) begin
      mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(2);
    end
    inc_btn = 1'b1;
    exp_q.push_back('{"rpt_press_edge", pk(2'b10, 0, 0, 5'd5, 6'd11), M_NOBL});
    exp_q.push_back('{"rpt_held_28", pk(2'b10, 0, 0, 5'd5, final_min), M_NOBL});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    tick(26);
    inc_btn = 1'b0;
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(2);
  endtask

  task automatic test_reset_mid;
    int load_start;
    cur_hour = 5'd7; cur_min = 6'd20;
    for (int k = 0; k < 2; k++) begin
      mode_btn = 1'b1; tick(2); mode_btn = 1'b0; tick(2);
    end
    load_start = n_load;
    exp_q.push_back('{"mid_in_set_min", pk(2'b10, 0, 0, 5'd7, 6'd20), M_NOBL});
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    @(posedge clk); #3;
    rst_n = 1'b0; mode_btn = 1'b1; inc_btn = 1'b1;
    exp_q.push_back('{"mid_async_clear", pk(2'b00, 0, 0, 5'd0, 6'd0), M_ALL});
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    tick(3);
    rst_n = 1'b1;
    exp_q.push_back('{"mid_held_no_event", pk(2'b00, 0, 0, 5'd0, 6'd0), M_ALL});
    exp_q.push_back('{"mid_after_release", pk(2'b00, 0, 0, 5'd0, 6'd0), M_ALL});
    tick(4);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b0; inc_btn = 1'b0;
    tick(3);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    n_cmp++;
    if ((n_load - load_start) !== 0) begin
      n_fail++; $display("FAIL mid_no_load: got %0d pulses expected 0", n_load - load_start);
    end
  endtask

  task automatic test_blink;
    cur_hour = 5'd3; cur_min = 6'd4;
    mode_btn = 1'b1;
    tick(2);
    mode_btn = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back('{"blink_hour", pk(2'b01, 0, (i < 8 || i == 16), 5'd0, 6'd0), M_BLINK});
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, i, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
    mode_btn = 1'b1;
    exp_q.push_back('{"blink_min_entry", pk(2'b10, 0, 1, 5'd0, 6'd0), M_BLINK});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b0; tick(2);
    mode_btn = 1'b1;
    exp_q.push_back('{"blink_load_off", pk(2'b00, 1, 0, 5'd0, 6'd0), M_BLINK | 15'h1000});
    exp_q.push_back('{"blink_run_off", pk(2'b00, 0, 0, 5'd0, 6'd0), M_BLINK | 15'h1000});
    tick(2);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
    mode_btn = 1'b0; tick(1);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs & e.mask, e.val & e.mask);
    end
  endtask

  initial begin
    test_reset();
    test_set_sequence();
    test_mode_inc_same();
    test_clamp();
    test_auto_repeat();
    test_reset_mid();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
